// File: rtl/spi_master_ctrl.sv
// SPI master controller for a byte-addressed slave RAM.
//
// A request (op + byte) is accepted in IDLE and turned into one SS_n-framed
// transfer. Each frame starts with a 0 bit, then a 3-bit header
// (op[1], op[1], op[0]), then 8 payload bits, MSB first.
//   op 00 / 10 : write / read address (payload = address), 12 cycles low
//   op 01      : write data (payload = data), 12 cycles low
//   op 11      : read data: 8 dummy zeros, one turnaround cycle, then 8 MISO
//                bits sampled MSB first; 21 cycles low, rsp_valid pulses as
//                SS_n rises
// After every frame SS_n stays high for IDLE_GAP cycles (GAP) plus the IDLE
// cycle in which the next request is accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/op/data     request from the requester
//   req_ready             high only in IDLE (and not in reset)
//   rsp_valid, rsp_data   one-cycle pulse with the byte read by an op 11
//   busy                  frame or inter-frame gap in progress
//   SS_n, MOSI, MISO      SPI pins (SS_n, MOSI, rsp_* are registered)
module spi_master_ctrl #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {StIdle, StFrame, StTurn, StRecv, StGap} state_e;

  localparam logic [4:0] LastTxCycle = 5'd11;
  localparam logic [4:0] LastRxCycle = 5'd20;
  localparam logic [4:0] GapLast     = 5'(IDLE_GAP - 1);

  state_e      state_q;
  logic [4:0]  cnt_q;      // frame cycle number, reused as the gap counter
  logic [1:0]  op_q;
  logic [10:0] tx_q;       // header + payload still to be shifted out
  logic [6:0]  rx_q;       // first seven received bits
  logic        ss_n_q;
  logic        mosi_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;

  // Gated by rst_n so no request can be accepted while reset is held.
  assign req_ready = rst_n && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            // Read-data frames carry dummy zeros instead of the payload.
            tx_q    <= {req_op[1], req_op[1], req_op[0],
                        (req_op == 2'b11) ? 8'h00 : req_data};
            ss_n_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StFrame;
          end
        end
        StFrame: begin
          if (cnt_q == LastTxCycle) begin
            mosi_q <= 1'b0;
            if (op_q == 2'b11) begin
              cnt_q   <= cnt_q + 5'd1;
              state_q <= StTurn;
            end else begin
              ss_n_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= StGap;
            end
          end else begin
            mosi_q <= tx_q[10];
            tx_q   <= {tx_q[9:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
          end
        end
        StTurn: begin
          cnt_q   <= cnt_q + 5'd1;
          state_q <= StRecv;
        end
        StRecv: begin
          rx_q <= {rx_q[5:0], MISO};
          if (cnt_q == LastRxCycle) begin
            // Last bit goes straight into the response with the SS_n rise.
            rsp_data_q  <= {rx_q, MISO};
            rsp_valid_q <= 1'b1;
            ss_n_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StGap;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed + random bench for spi_master_ctrl with an SPI slave/RAM model.
module tb_spi_master_ctrl;

  localparam int unsigned IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b1;

  spi_master_ctrl #(.IDLE_GAP(IDLE_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave + RAM model, decoding frames from the pins.
  logic [7:0]  ram [256];
  int          s_cnt;
  logic [10:0] s_bits;
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  s_rd = 8'h00;

  always @(posedge clk) begin
    if (!rst_n || SS_n) begin
      s_cnt  = 0;
      s_bits = '0;
      MISO  <= 1'b1;
      if (rst_n) check_eq("mosi_idle", 32'(MOSI), 32'h0);
    end else begin
      s_bits = {s_bits[9:0], MOSI};
      if (s_cnt == 11) begin
        case ({s_bits[10], s_bits[8]})
          2'b00, 2'b10: s_addr = s_bits[7:0];
          2'b01:        ram[s_addr] = s_bits[7:0];
          default:      s_rd = ram[s_addr];
        endcase
      end
      if (s_cnt + 1 >= 13 && s_cnt + 1 <= 20) MISO <= s_rd[20 - (s_cnt + 1)];
      else MISO <= 1'b1;
      s_cnt++;
    end
  end

  // Scoreboard built from issued requests.
  logic [7:0]  sb_mem [256];
  logic [7:0]  sb_addr = 8'h00;
  logic [7:0]  sb_exp = 8'h00;
  logic [7:0]  last_rsp = 8'h00;
  logic [31:0] mosi_v;
  time         t_fall, t_rise, tr;
  logic [1:0]  op_r;
  logic [7:0]  data_r;

  task automatic start_req(input logic [1:0] op, input logic [7:0] data);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("hs_wait", 32'(n < 100), 32'h1);
    @(posedge clk);
    #1;
    case (op)
      2'b00, 2'b10: sb_addr = data;
      2'b01:        sb_mem[sb_addr] = data;
      default:      sb_exp = sb_mem[sb_addr];
    endcase
  endtask

  task automatic run_frame(input logic [1:0] op, input logic [7:0] data, input bit hold);
    int low;
    int vcnt;
    start_req(op, data);
    if (!hold) req_valid = 1'b0;
    mosi_v = '0;
    low    = 0;
    vcnt   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (SS_n) break;
      if (k == 0) begin
        t_fall = $time;
        check_eq("busy_in_frame", 32'({req_ready, busy}), 32'h1);
      end
      if (hold && k == 3) begin
        req_op   = ~op;
        req_data = ~data;
      end
      mosi_v = {mosi_v[30:0], MOSI};
      if (rsp_valid) vcnt++;
      low++;
    end
    t_rise = $time;
    check_eq("mosi_at_rise", 32'(MOSI), 32'h0);
    check_eq("valid_in_frame", 32'(vcnt), 32'h0);
    if (op == 2'b11) begin
      check_eq("rd_len", 32'(low), 32'd21);
      check_eq("rd_mosi", 32'(mosi_v[20:8]), 32'h0E00);
      check_eq("rd_valid", 32'(rsp_valid), 32'h1);
      check_eq("rd_data", 32'(rsp_data), 32'(sb_exp));
      last_rsp = sb_exp;
    end else begin
      check_eq("wr_len", 32'(low), 32'd12);
      check_eq("wr_mosi", 32'(mosi_v[11:0]), 32'({1'b0, op[1], op, data}));
      check_eq("wr_valid", 32'(rsp_valid), 32'h0);
      check_eq("rsp_hold", 32'(rsp_data), 32'(last_rsp));
    end
    @(negedge clk);
    check_eq("valid_one_cycle", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'h00;
      sb_mem[i] = 8'h00;
    end
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ss", 32'(SS_n), 32'h1);
    check_eq("rst_mosi", 32'(MOSI), 32'h0);
    check_eq("rst_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_data", 32'(rsp_data), 32'h0);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Write address A5.
    run_frame(2'b00, 8'hA5, 1'b0);
    check_eq("a5_mosi", 32'(mosi_v[11:0]), 32'h0A5);

    // Back-to-back write data 3C then read address 0F.
    run_frame(2'b01, 8'h3C, 1'b0);
    check_eq("3c_mosi", 32'(mosi_v[11:0]), 32'h13C);
    tr = t_rise;
    run_frame(2'b10, 8'h0F, 1'b0);
    check_eq("0f_mosi", 32'(mosi_v[11:0]), 32'h60F);
    check_eq("b2b_gap", 32'((t_fall - tr) / 10), IDLE_GAP + 1);

    // Write C3 to 0F, read it back.
    run_frame(2'b01, 8'hC3, 1'b0);
    run_frame(2'b11, 8'h55, 1'b0);
    check_eq("c3_data", 32'(rsp_data), 32'hC3);

    // req_valid held through a frame while op/data change mid-frame.
    run_frame(2'b01, 8'h5A, 1'b1);
    check_eq("hold_mosi", 32'(mosi_v[11:0]), 32'h15A);
    tr = t_rise;
    run_frame(2'b10, 8'hA5, 1'b0);
    check_eq("hold_gap", 32'((t_fall - tr) / 10), IDLE_GAP + 1);
    run_frame(2'b11, 8'h00, 1'b0);
    check_eq("3c_data", 32'(rsp_data), 32'h3C);
    // Read data with no preceding read address.
    run_frame(2'b11, 8'hFF, 1'b0);
    check_eq("3c_again", 32'(rsp_data), 32'h3C);

    // Reset in RECV cycle 16 of a read-data frame.
    start_req(2'b11, 8'h00);
    req_valid = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("pre_abort_ss", 32'(SS_n), 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ss", 32'(SS_n), 32'h1);
    check_eq("abort_mosi", 32'(MOSI), 32'h0);
    check_eq("abort_valid", 32'(rsp_valid), 32'h0);
    check_eq("abort_data", 32'(rsp_data), 32'h0);
    check_eq("abort_ready", 32'(req_ready), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_no_valid", 32'(rsp_valid), 32'h0);
    end
    rst_n    = 1'b1;
    tr       = $time;
    last_rsp = 8'h00;
    #1;
    run_frame(2'b00, 8'h0F, 1'b0);
    check_eq("first_hs", 32'((t_fall - tr) / 10), 32'd1);

    // Random traffic against the slave RAM; addresses kept small for reuse.
    for (int i = 0; i < 3000; i++) begin
      op_r   = 2'($urandom_range(0, 3));
      data_r = (op_r == 2'b00 || op_r == 2'b10) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      run_frame(op_r, data_r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
